// File: rtl/wb_stage.sv
// Writeback stage: registers one retiring instruction per cycle, selects and
// sign-extends the writeback value, flags load faults and counts retirements.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [6:0]       opcode,
    input  logic [2:0]       f3,
    input  logic [4:0]       rd_in,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  Imm,
    output logic             in_ready,
    output logic [XLEN-1:0]  DIn,
    output logic             WrEn,
    output logic [4:0]       rd,
    output logic             misalign,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_IALU  = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_LUI   = 7'b0110111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_LOAD  = 7'b0000011
    } opcode_e;

    logic            w_accept;
    logic            w_writes;
    logic            w_mis;
    logic            w_ill;
    logic [XLEN-1:0] w_value;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    logic             r_v;
    logic             r_writes;
    logic             r_mis;
    logic             r_ill;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_value;
    logic [CNT_W-1:0] r_instret;

    assign in_ready = !stall;
    assign w_accept = in_valid && !stall && !flush;

    assign w_byte = mem_rdata[{alu_res[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{alu_res[1], 4'b0000} +: 16];

    always_comb begin
        w_writes = 1'b0;
        w_mis    = 1'b0;
        w_ill    = 1'b0;
        w_value  = '0;
        case (opcode)
            OP_R, OP_IALU, OP_AUIPC: begin
                w_writes = 1'b1;
                w_value  = alu_res;
            end
            OP_LUI: begin
                w_writes = 1'b1;
                w_value  = Imm;
            end
            OP_JAL, OP_JALR: begin
                w_writes = 1'b1;
                w_value  = pc_plus4;
            end
            OP_LOAD: begin
                w_writes = 1'b1;
                case (f3)
                    3'b000: w_value = {{(XLEN-8){w_byte[7]}}, w_byte};
                    3'b100: w_value = {{(XLEN-8){1'b0}}, w_byte};
                    3'b001, 3'b101: begin
                        w_value = f3[2] ? {{(XLEN-16){1'b0}}, w_half}
                                        : {{(XLEN-16){w_half[15]}}, w_half};
                        w_mis   = alu_res[0];
                    end
                    3'b010: begin
                        w_value = mem_rdata;
                        w_mis   = (alu_res[1:0] != 2'b00);
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Data registers only load on accept; bubbles are marked by r_v alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v       <= 1'b0;
            r_writes  <= 1'b0;
            r_mis     <= 1'b0;
            r_ill     <= 1'b0;
            r_rd      <= '0;
            r_value   <= '0;
            r_instret <= '0;
        end else begin
            if (r_v && !r_mis && !r_ill)
                r_instret <= r_instret + CNT_W'(1);
            r_v <= w_accept;
            if (w_accept) begin
                r_writes <= w_writes;
                r_mis    <= w_mis;
                r_ill    <= w_ill;
                r_rd     <= rd_in;
                r_value  <= w_value;
            end
        end
    end

    assign WrEn     = r_v && r_writes && !r_mis && !r_ill && (r_rd != 5'd0);
    assign DIn      = WrEn ? r_value : '0;
    assign rd       = r_rd;
    assign misalign = r_v && r_mis;
    assign illegal  = r_v && r_ill;
    assign instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the writeback rules.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd_in;
    logic [31:0] alu_res, mem_rdata, pc_plus4, Imm;
    logic        in_ready, WrEn, misalign, illegal;
    logic [31:0] DIn;
    logic [4:0]  rd;
    logic [63:0] instret;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .opcode(opcode), .f3(f3), .rd_in(rd_in), .alu_res(alu_res),
        .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .Imm(Imm),
        .in_ready(in_ready), .DIn(DIn), .WrEn(WrEn), .rd(rd),
        .misalign(misalign), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          w;
        bit [31:0]   val;
        bit          mis;
        bit          ill;
    } cap_t;

    // Expected effect of one instruction, from the writeback rules.
    function automatic cap_t ref_cap(bit [6:0] op, bit [2:0] fn, bit [31:0] alu,
                                     bit [31:0] mem, bit [31:0] pc4, bit [31:0] imm);
        cap_t c;
        int unsigned a, b, h;
        c = '{w: 0, val: 0, mis: 0, ill: 0};
        a = alu % 4;
        b = (mem >> (8 * a)) % 256;
        h = (mem >> (16 * (a / 2))) % 65536;
        if (op == 7'h33 || op == 7'h13 || op == 7'h17) begin c.w = 1; c.val = alu; end
        else if (op == 7'h37) begin c.w = 1; c.val = imm; end
        else if (op == 7'h6F || op == 7'h67) begin c.w = 1; c.val = pc4; end
        else if (op == 7'h03) begin
            c.w = 1;
            case (fn)
                0: c.val = (b >= 128) ? b - 256 : b;
                4: c.val = b;
                1: begin c.val = (h >= 32768) ? h - 65536 : h; c.mis = (a % 2) != 0; end
                5: begin c.val = h; c.mis = (a % 2) != 0; end
                2: begin c.val = mem; c.mis = a != 0; end
                default: c.ill = 1;
            endcase
        end
        return c;
    endfunction

    bit          m_v = 0;
    cap_t        m_c;
    bit [4:0]    m_rd = 0;
    bit [63:0]   m_cnt = 0;
    int unsigned wr_pulses = 0;
    bit          saw_flushed = 0;

    task automatic tick();
        bit exp_we;
        bit was_rst;
        #1 check("in_ready", in_ready, !stall);
        @(posedge clk);
        was_rst = rst;
        if (rst) begin
            m_v = 0; m_rd = 0; m_cnt = 0;
        end else begin
            if (m_v && !m_c.mis && !m_c.ill) m_cnt++;
            m_v = in_valid && !stall && !flush;
            if (m_v) begin
                m_c  = ref_cap(opcode, f3, alu_res, mem_rdata, pc_plus4, Imm);
                m_rd = rd_in;
            end
        end
        #1;
        exp_we = m_v && m_c.w && !m_c.mis && !m_c.ill && (m_rd != 0);
        check("WrEn", WrEn, exp_we);
        check("DIn", DIn, exp_we ? m_c.val : 32'h0);
        check("misalign", misalign, m_v && m_c.mis);
        check("illegal", illegal, m_v && m_c.ill);
        check("instret", instret, m_cnt);
        if (exp_we || was_rst) check("rd", rd, m_rd);
        if (WrEn) wr_pulses++;
        if (WrEn && DIn == 32'hDEAD0000) saw_flushed = 1;
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input bit f,
                         input bit [6:0] op, input bit [2:0] fn, input bit [4:0] d,
                         input bit [31:0] alu, input bit [31:0] mem,
                         input bit [31:0] pc4, input bit [31:0] imm);
        rst = r; in_valid = v; stall = s; flush = f; opcode = op; f3 = fn;
        rd_in = d; alu_res = alu; mem_rdata = mem; pc_plus4 = pc4; Imm = imm;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 7'h33, 0, 1, 32'h1, 0, 0, 0);
    endtask

    task automatic add(input bit [4:0] d, input bit [31:0] v, input bit s, input bit f);
        drive(0, 1, s, f, 7'h33, 0, d, v, 0, 0, 0);
    endtask

    localparam bit [31:0] MEM = 32'h80FF7F01;
    bit [6:0] ops[12] = '{7'h33, 7'h13, 7'h17, 7'h37, 7'h6F, 7'h67,
                          7'h03, 7'h03, 7'h03, 7'h23, 7'h63, 7'h73};

    initial begin
        bit [63:0] cnt0;
        // Reset with valid input present
        drive(1, 1, 0, 0, 7'h33, 0, 3, 32'h55, 0, 0, 0);
        drive(1, 1, 1, 1, 7'h33, 0, 3, 32'h55, 0, 0, 0);
        check("rst_wren", WrEn, 0);
        check("rst_din", DIn, 0);
        check("rst_rd", rd, 0);
        check("rst_cnt", instret, 0);

        add(5, 32'h12345678, 0, 0);
        check("add_wren", WrEn, 1);
        check("add_din", DIn, 32'h12345678);
        check("add_rd", rd, 5);
        idle();
        check("add_cnt", instret, 1);

        drive(0, 1, 0, 0, 7'h03, 3'b000, 1, 32'h1003, MEM, 0, 0);
        check("lb", DIn, 32'hFFFFFF80);
        drive(0, 1, 0, 0, 7'h03, 3'b100, 2, 32'h1001, MEM, 0, 0);
        check("lbu", DIn, 32'h0000007F);
        drive(0, 1, 0, 0, 7'h03, 3'b001, 3, 32'h1002, MEM, 0, 0);
        check("lh", DIn, 32'hFFFF80FF);
        drive(0, 1, 0, 0, 7'h03, 3'b101, 4, 32'h1000, MEM, 0, 0);
        check("lhu", DIn, 32'h00007F01);
        idle();
        cnt0 = instret;
        drive(0, 1, 0, 0, 7'h03, 3'b010, 6, 32'h1001, MEM, 0, 0);
        check("lw_mis_pulse", misalign, 1);
        check("lw_mis_wren", WrEn, 0);
        idle();
        check("lw_mis_pulse_end", misalign, 0);
        check("lw_mis_cnt", instret, cnt0);

        drive(0, 1, 0, 0, 7'h6F, 0, 1, 0, 0, 32'h104, 0);
        check("jal", DIn, 32'h104);
        drive(0, 1, 0, 0, 7'h37, 0, 2, 0, 0, 0, 32'hABCDE000);
        check("lui", DIn, 32'hABCDE000);
        idle();
        cnt0 = instret;
        add(0, 32'h77, 0, 0);
        check("rd0_wren", WrEn, 0);
        drive(0, 1, 0, 0, 7'h23, 3'b010, 9, 32'h40, 0, 0, 0);
        check("sw_wren", WrEn, 0);
        drive(0, 1, 0, 0, 7'h03, 3'b110, 9, 32'h40, MEM, 0, 0);
        check("ill_pulse", illegal, 1);
        idle();
        check("misc_cnt", instret, cnt0 + 2);

        // Handshake: stalls insert bubbles, flush drops the presented instr.
        drive(1, 0, 0, 0, 7'h33, 0, 0, 0, 0, 0, 0);
        wr_pulses = 0;
        saw_flushed = 0;
        add(10, 32'hA0, 0, 0);
        add(11, 32'hA1, 1, 0);
        add(11, 32'hA1, 1, 0);
        add(11, 32'hA1, 0, 0);
        add(31, 32'hDEAD0000, 0, 1);
        add(12, 32'hA2, 0, 0);
        add(13, 32'hA3, 0, 0);
        idle();
        idle();
        check("hs_pulses", wr_pulses, 4);
        check("hs_flushed", saw_flushed, 0);
        check("hs_cnt", instret, 4);

        // Counter wrap through a preloaded value.
        force dut.r_instret = '1;
        m_cnt = '1;
        #1 release dut.r_instret;
        check("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        add(1, 32'h1, 0, 0);
        idle();
        check("wrap", instret, 0);

        // Reset while an instruction is held: it retires no count.
        add(7, 32'h9, 0, 0);
        idle();
        add(7, 32'h99, 0, 0);
        drive(1, 1, 0, 0, 7'h33, 0, 8, 32'h88, 0, 0, 0);
        check("rst_mid_wren", WrEn, 0);
        check("rst_mid_cnt", instret, 0);
        idle();
        check("rst_mid_cnt2", instret, 0);

        for (int i = 0; i < 1500; i++) begin
            bit [6:0] op;
            op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  op, 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the alpha-processor pipeline. It is the producer side of the register-file write port that the decode stage consumes. It registers one retiring instruction per cycle, extracts and sign-extends load data, and selects the writeback value. It then drives `DIn`, `WrEn` and the destination register back into decode, and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  incoming instruction is valid this cycle.
- `stall`  in  1  hold off capture this cycle.
- `flush`  in  1  discard the incoming instruction this cycle.
- `opcode`  in  7  opcode of the incoming instruction.
- `f3`  in  3  funct3 of the incoming instruction.
- `rd_in`  in  5  destination register.
- `alu_res`  in  XLEN  ALU result; also the load address.
- `mem_rdata`  in  XLEN  word-aligned load data.
- `pc_plus4`  in  XLEN  link value for JAL/JALR.
- `Imm`  in  XLEN  immediate; the value written for LUI.
- `in_ready`  out  1  equals `!stall`; combinational.
- `DIn`  out  XLEN  writeback data to the register file.
- `WrEn`  out  1  register-file write enable.
- `rd`  out  5  writeback destination.
- `misalign`  out  1  one-cycle pulse: misaligned load dropped.
- `illegal`  out  1  one-cycle pulse: illegal load funct3 dropped.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
Capture:
- Capture occurs when `in_valid && !stall && !flush`. The stage latches `opcode`, `f3`, `rd_in`, the selected value, the fault bits, and sets `v_q=1`.
- Otherwise `v_q=0` next cycle. This inserts a bubble; data registers are don't-care.
- Each accepted instruction therefore produces exactly one output cycle.
- `flush` overrides `in_valid`. The instruction already held in the register still retires.

Value select, computed before the register:
- 0110011 / 0010011 / 0010111 (R, I-ALU, AUIPC): `alu_res`.
- 0110111 (LUI): `Imm`.
- 1101111 / 1100111 (JAL, JALR): `pc_plus4`.
- 0000011 (LOAD): byte select `a=alu_res[1:0]`.
  - f3=000 LB: `mem_rdata[8a+7:8a]` sign-extended.
  - f3=100 LBU: same byte, zero-extended.
  - f3=001 LH / f3=101 LHU: half `mem_rdata[16a[1]+15:16a[1]]`, sign-/zero-extended.
  - f3=010 LW: `mem_rdata`.
- All other opcodes (store, branch, fence, system, unknown): no write.

Faults:
- Misaligned: LH/LHU with `a[0]=1`, or LW with `a!=0`.
- Illegal: load f3 of 011, 110 or 111.
- A faulting instruction does not write. It pulses `misalign` or `illegal` and does not increment `instret`.

Outputs, all from the pipeline register:
- `WrEn = v_q && writes_q && !fault_q && rd!=0`.
- `DIn` = registered value; 0 when `WrEn=0`.
- `instret` increments by 1 when `v_q && !fault_q`, including non-writing stores and branches.
- `instret` wraps modulo 2^CNT_W.

## Timing
- Latency: an instruction accepted at edge N drives `DIn`/`WrEn`/`rd` during cycle N+1; the register file writes at edge N+2.
- Throughput: 1 instruction per cycle. Back-to-back accepts produce back-to-back `WrEn` pulses.
- `stall` held for k cycles yields k bubble cycles with `WrEn=0`. Nothing is duplicated.
- `rst` is synchronous. At the first edge with `rst=1`, every output is cleared: `v_q=0`, `WrEn=0`, `DIn=0`, `rd=0`, `misalign=0`, `illegal=0`, `instret=0`.
  - `in_ready` follows `stall` even during reset.
- `rst` has priority over capture and over the counter increment. An instruction held at reset is discarded and not counted.
- `rst`, `flush` and `stall` may be asserted simultaneously; `rst` wins, then `flush`/`stall` (equivalent: no capture).
- The `rd=0` write is suppressed, but the instruction is still counted.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid=1` → all outputs 0; `instret=0`.
- ALU writeback: ADD, `alu_res=0x12345678`, `rd_in=5`, accepted at edge N → at N+1 `WrEn=1`, `DIn=0x12345678`, `rd=5`; `instret=1`.
- Loads: `mem_rdata=0x80FF7F01`.
  - LB with a=3 → `0xFFFFFF80`.
  - LBU with a=1 → `0x0000007F`.
  - LH with a=2 → `0xFFFF80FF`.
  - LHU with a=0 → `0x00007F01`.
  - LW with a=1 → no write, `misalign` pulse, `instret` unchanged.
- Misc:
  - JAL with `pc_plus4=0x104` → `DIn=0x104`.
  - LUI with `Imm=0xABCDE000` → that value.
  - `rd_in=0` → `WrEn=0`, `instret` increments.
  - SW → `WrEn=0`, `instret` increments.
  - Load with f3=110 → `illegal` pulse.
- Handshake: 4 back-to-back ADDs, `stall` high on cycle 2 for 2 cycles, then `flush` on cycle 5 with `in_valid=1` → exactly 4 `WrEn` pulses, gaps match the stalls, the flushed instruction is never written, `instret=4`.
- Counter wrap: preload `instret` via force to 2^64−1, retire one instruction → `instret=0`. Then assert `rst` mid-stream while an instruction is held → that instruction is not written and not counted.
